// File: rtl/crc8_checker.sv
// CRC-8 frame checker: folds payload bytes into a CRC and compares it with the trailing CRC byte.
// Define CRC8_CHECKER_STATS_EN to add saturating frame_cnt/err_cnt outputs.
module crc8_checker #(
  parameter logic [7:0]  POLY      = 8'hED,
  parameter logic [15:0] MAX_BYTES = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [7:0]  crc_calc
`ifdef CRC8_CHECKER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  logic [1:0]  state;
  logic [7:0]  crc_reg;
  logic [7:0]  rx_crc;
  logic [15:0] byte_cnt;
  logic        len_flag;
  logic        ready_en;
  logic        accept;

  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // ready_en keeps in_ready low during reset and rises on the first clock after release
  assign in_ready   = ready_en && (state != CHECK);
  assign accept     = in_valid && in_ready;
  assign frame_done = (state == CHECK);
  assign crc_ok     = frame_done && !len_flag && (rx_crc == crc_reg);
  assign crc_err    = frame_done && !crc_ok;
  assign len_err    = frame_done && len_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc_reg  <= 8'h00;
      rx_crc   <= 8'h00;
      byte_cnt <= 16'd0;
      len_flag <= 1'b0;
      ready_en <= 1'b0;
      crc_calc <= 8'h00;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE, DATA: begin
          if (accept) begin
            if (in_last) begin
              // The CRC byte is latched for comparison, never folded in
              rx_crc   <= data_in;
              crc_calc <= crc_reg;
              state    <= CHECK;
            end else if ((state == DATA) && (byte_cnt == MAX_BYTES)) begin
              len_flag <= 1'b1;
              state    <= DROP;
            end else begin
              crc_reg  <= crc_step(crc_reg, data_in);
              byte_cnt <= byte_cnt + 16'd1;
              state    <= DATA;
            end
          end
        end
        DROP: begin
          if (accept && in_last) begin
            rx_crc   <= data_in;
            crc_calc <= crc_reg;
            state    <= CHECK;
          end
        end
        CHECK: begin
          crc_reg  <= 8'h00;
          byte_cnt <= 16'd0;
          len_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRC8_CHECKER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      if (frame_done && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
      if (crc_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_checker.sv
// Self-checking bench for crc8_checker: a frame-level reference model checked every cycle,
// plus hand-computed per-frame expectations. Define CRC8_CHECKER_STATS_EN to also check counters.
module tb_crc8_checker;

  localparam logic [7:0]  POLY = 8'hED;
  localparam logic [15:0] MAXB = 16'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready, frame_done, crc_ok, crc_err, len_err;
  logic [7:0]  crc_calc;
`ifdef CRC8_CHECKER_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  crc8_checker #(.POLY(POLY), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .frame_done(frame_done), .crc_ok(crc_ok), .crc_err(crc_err),
    .len_err(len_err), .crc_calc(crc_calc)
`ifdef CRC8_CHECKER_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Polynomial long division over the message bit stream, MSB first
  function automatic logic [7:0] crcOf(input logic [7:0] bytes[$], input int limit);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    for (int i = 0; i < bytes.size() && i < limit; i++) begin
      for (int k = 7; k >= 0; k--) begin
        fb = r[7] ^ bytes[i][k];
        r = {r[6:0], 1'b0};
        if (fb) r = r ^ POLY;
      end
    end
    return r;
  endfunction

  // Reference model: collects the frame, judges it when the last byte arrives
  logic [7:0]  payload[$];
  logic        m_ready_en, m_check, e_len, e_match;
  logic [7:0]  e_calc;
  logic [15:0] e_frames, e_errs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready_en <= 1'b0;
      m_check    <= 1'b0;
      e_calc     <= 8'h00;
      e_len      <= 1'b0;
      e_match    <= 1'b0;
      e_frames   <= 16'd0;
      e_errs     <= 16'd0;
      payload.delete();
    end else begin
      m_ready_en <= 1'b1;
      if (m_check) begin
        m_check <= 1'b0;
        if (e_frames != 16'hFFFF) e_frames <= e_frames + 16'd1;
        if ((e_len || !e_match) && e_errs != 16'hFFFF) e_errs <= e_errs + 16'd1;
      end else if (m_ready_en && in_valid) begin
        if (in_last) begin
          m_check <= 1'b1;
          e_calc  <= crcOf(payload, int'(MAXB));
          e_len   <= (payload.size() > int'(MAXB));
          e_match <= (data_in == crcOf(payload, int'(MAXB)));
          payload.delete();
        end else begin
          payload.push_back(data_in);
        end
      end
    end
  end

  logic exp_ok;
  always @(negedge clk) begin
    exp_ok = m_check && !e_len && e_match;
    checkOutput("in_ready", 16'(in_ready), 16'(m_ready_en && !m_check));
    checkOutput("frame_done", 16'(frame_done), 16'(m_check));
    checkOutput("crc_ok", 16'(crc_ok), 16'(exp_ok));
    checkOutput("crc_err", 16'(crc_err), 16'(m_check && !exp_ok));
    checkOutput("len_err", 16'(len_err), 16'(m_check && e_len));
    checkOutput("crc_calc", 16'(crc_calc), 16'(e_calc));
`ifdef CRC8_CHECKER_STATS_EN
    checkOutput("frame_cnt", frame_cnt, e_frames);
    checkOutput("err_cnt", err_cnt, e_errs);
`endif
  end

  task automatic applyStimulus(input logic [7:0] b, input logic last, input logic valid);
    data_in  = b;
    in_last  = last;
    in_valid = valid;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge inside the CHECK cycle
  task automatic sendFrame(input logic [7:0] bytes[$], input logic [7:0] crc_byte);
    foreach (bytes[i]) applyStimulus(bytes[i], 1'b0, 1'b1);
    applyStimulus(crc_byte, 1'b1, 1'b1);
  endtask

  task automatic checkFrame(input string tag, input logic ok, input logic err, input logic len,
                            input logic [7:0] calc);
    checkOutput({tag, "_done"}, 16'(frame_done), 16'd1);
    checkOutput({tag, "_ok"}, 16'(crc_ok), 16'(ok));
    checkOutput({tag, "_err"}, 16'(crc_err), 16'(err));
    checkOutput({tag, "_len"}, 16'(len_err), 16'(len));
    checkOutput({tag, "_calc"}, 16'(crc_calc), 16'(calc));
    checkOutput({tag, "_ready"}, 16'(in_ready), 16'd0);
  endtask

  logic [7:0] q[$];

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 16'(in_ready), 16'd0);
    checkOutput("rst_calc", 16'(crc_calc), 16'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", 16'(in_ready), 16'd1);

    q = '{8'h01};
    sendFrame(q, 8'hED);
    checkFrame("f1", 1'b1, 1'b0, 1'b0, 8'hED);
    applyStimulus(8'h00, 1'b0, 1'b0);

    q = '{8'h01, 8'h00};
    sendFrame(q, 8'hD3);
    checkFrame("f2", 1'b1, 1'b0, 1'b0, 8'hD3);
    applyStimulus(8'h55, 1'b0, 1'b1);   // offered during CHECK, must be refused
    applyStimulus(8'h00, 1'b0, 1'b0);

    q = '{8'h01};
    sendFrame(q, 8'hEC);
    checkFrame("f3", 1'b0, 1'b1, 1'b0, 8'hED);
    applyStimulus(8'h00, 1'b0, 1'b0);
`ifdef CRC8_CHECKER_STATS_EN
    checkOutput("f3_err_cnt", err_cnt, 16'd1);
    checkOutput("f3_frame_cnt", frame_cnt, 16'd3);
`endif

    q = {};
    sendFrame(q, 8'h00);
    checkFrame("f4", 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);

    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sendFrame(q, 8'h00);
    checkFrame("f5", 1'b0, 1'b1, 1'b1, crcOf(q, int'(MAXB)));
    applyStimulus(8'h00, 1'b0, 1'b0);

    q = '{8'h00, 8'h00, 8'h00, 8'h01};
    sendFrame(q, 8'hED);
    checkFrame("f6", 1'b1, 1'b0, 1'b0, 8'hED);
    applyStimulus(8'h00, 1'b0, 1'b0);

    q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hAA};
    sendFrame(q, 8'hED);
    checkFrame("f7", 1'b0, 1'b1, 1'b1, 8'hED);
    applyStimulus(8'h00, 1'b0, 1'b0);

    applyStimulus(8'h01, 1'b0, 1'b1);
    applyStimulus(8'hEE, 1'b1, 1'b0);   // last without valid is ignored
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h77, 1'b0, 1'b0);
    applyStimulus(8'hD3, 1'b1, 1'b1);
    checkFrame("f8", 1'b1, 1'b0, 1'b0, 8'hD3);
    applyStimulus(8'h00, 1'b0, 1'b0);

    applyStimulus(8'h01, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_done", 16'(frame_done), 16'd0);
    checkOutput("midrst_ready", 16'(in_ready), 16'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    q = {};
    sendFrame(q, 8'h00);
    checkFrame("f9", 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
